// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined ALU between NUM_REQ requesters, routing results back by tag.
// Optional grant locking is compiled in with `define ALU_ARB_LOCK_EN.
module alu_rr_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 32,
    parameter int ALU_LATENCY = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*4-1:0]       req_opcode,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*5-1:0]       req_shift,
    input  logic [NUM_REQ-1:0]         req_lock,
    output logic                       alu_rst,
    output logic [3:0]                 alu_opcode,
    output logic [WIDTH-1:0]           alu_input1,
    output logic [WIDTH-1:0]           alu_input2,
    output logic [4:0]                 alu_shift,
    input  logic [WIDTH-1:0]           alu_result,
    input  logic                       alu_carry,
    input  logic                       alu_zero,
    input  logic                       alu_sign,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_result,
    output logic [2:0]                 rsp_flags,
    output logic                       busy
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [3:0]       opcode_arr [NUM_REQ];
    logic [WIDTH-1:0] a_arr      [NUM_REQ];
    logic [WIDTH-1:0] b_arr      [NUM_REQ];
    logic [4:0]       shift_arr  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign opcode_arr[gi] = req_opcode[4*gi +: 4];
            assign a_arr[gi]      = req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]      = req_b[WIDTH*gi +: WIDTH];
            assign shift_arr[gi]  = req_shift[5*gi +: 5];
        end
    endgenerate

    logic [IDW-1:0]     rr_ptr_reg;
    logic [IDW-1:0]     rr_ptr_next;
    logic [IDW-1:0]     grant_id;
    logic               grant_any;
    logic               hs;
    logic [NUM_REQ-1:0] grant;
    int                 idx;

`ifdef ALU_ARB_LOCK_EN
    logic           lock_active_reg;
    logic [IDW-1:0] lock_owner_reg;
`endif

    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % NUM_REQ;
            if (!grant_any && req_valid[idx]) begin
                grant_any = 1'b1;
                grant_id  = IDW'(idx);
            end
        end
`ifdef ALU_ARB_LOCK_EN
        // A live lock overrides the round-robin search for as long as the owner stays valid.
        if (lock_active_reg && req_valid[lock_owner_reg]) begin
            grant_any = 1'b1;
            grant_id  = lock_owner_reg;
        end
`endif
    end

    assign hs        = grant_any & rst_n;
    assign grant     = hs ? (NUM_REQ'(1) << grant_id) : '0;
    assign req_ready = grant;
    assign alu_rst   = ~rst_n;

    assign alu_opcode = hs ? opcode_arr[grant_id] : 4'd0;
    assign alu_input1 = hs ? a_arr[grant_id]      : '0;
    assign alu_input2 = hs ? b_arr[grant_id]      : '0;
    assign alu_shift  = hs ? shift_arr[grant_id]  : 5'd0;

    assign rr_ptr_next = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_reg <= '0;
        end else if (hs) begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_active_reg <= 1'b0;
            lock_owner_reg  <= '0;
        end else begin
            if (lock_active_reg && !req_valid[lock_owner_reg]) begin
                lock_active_reg <= 1'b0;
            end
            if (hs) begin
                lock_active_reg <= req_lock[grant_id];
                lock_owner_reg  <= grant_id;
            end
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
`endif

    // Tag pipe mirrors the ALU pipeline so the ID emerges alongside its result.
    logic [ALU_LATENCY-1:0] tag_valid_reg;
    logic [IDW-1:0]         tag_id_reg [ALU_LATENCY];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else begin
            tag_valid_reg[0] <= hs;
            tag_id_reg[0]    <= grant_id;
        end
    end

    generate
        for (gi = 1; gi < ALU_LATENCY; gi++) begin : g_tag
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = rst_n & tag_valid_reg[ALU_LATENCY-1]
                                   & (tag_id_reg[ALU_LATENCY-1] == IDW'(gi));
        end
    endgenerate

    assign busy       = rst_n & (|tag_valid_reg);
    assign rsp_result = alu_result;
    assign rsp_flags  = {alu_carry, alu_zero, alu_sign};
endmodule
